// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 BCM scan driver.
//   state_t      : shift/latch sequencer states
//   clog2        : ceiling log2 for parameter-derived widths
//   *_FIELD      : channel index inside a {blue,green,red} RAM word
//                  (multiply by COLOR_BITS for the LSB position)
package hub75_pkg;

  typedef enum logic [2:0] {
    SHIFT_ADDR,
    SHIFT_LO,
    SHIFT_HI,
    WAIT,
    BLANK,
    LATCH,
    UNBLANK
  } state_t;

  localparam int unsigned RED_FIELD   = 0;
  localparam int unsigned GREEN_FIELD = 1;
  localparam int unsigned BLUE_FIELD  = 2;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r = 0;
    while ((64'd1 << r) < 64'(value)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/hub75_plane_timer.sv
// Per-plane display timer.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : start a new plane (load_val cycles long, on_ticks lit)
//   blank      : force the panel dark this cycle
//   load_val   : plane duration in clk cycles
//   on_ticks   : lit cycles at the start of the plane
//   oe_n       : registered output enable, low = LEDs on
//   done       : timer has reached zero (previous plane finished)
module hub75_plane_timer #(
  parameter int unsigned TW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          blank,
  input  logic [TW-1:0] load_val,
  input  logic [TW-1:0] on_ticks,
  output logic          oe_n,
  output logic          done
);

  logic [TW-1:0] timer;
  logic [TW-1:0] thresh;

  // oe_n is registered from the current timer value, so the panel goes
  // lit one cycle after the load cycle; this keeps OE_N high while the
  // (equally registered) LE pulse is on the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer  <= '0;
      thresh <= '0;
      oe_n   <= 1'b1;
    end else begin
      if (load) begin
        timer  <= load_val;
        thresh <= load_val - on_ticks;
      end else if (timer != '0) begin
        timer <= timer - 1'b1;
      end
      oe_n <= blank || !(timer > thresh);
    end
  end

  assign done = (timer == '0);

endmodule

// File: rtl/hub75_bcm_driver.sv
// HUB75 panel scan driver with binary-coded modulation.
// Shifts bit plane p of a row pair out of a synchronous frame RAM while the
// previously latched plane is displayed for BASE_TICKS<<p cycles, dimmed by
// a global brightness applied to the OE_N duty.
//   clk, rst            : clock, asynchronous active-low reset
//   RED/GREEN/BLUE      : [0] upper-half bit, [1] lower-half bit
//   A, LE, OE_N, CLK    : panel row address, latch, output enable, shift clock
//   selected_buffer     : requested front buffer (taken at frame start)
//   actual_buffer       : buffer being scanned
//   rd_addr             : {actual_buffer,row,col} to the frame RAM
//   rd_data_hi/_lo      : {blue,green,red} pixel words, 1 clk after rd_addr
//   brightness          : global dim, taken at frame start
//   frame_start         : 1-clk pulse when row 0 plane 0 is latched
// All panel pins are registered and trail the sequencer state by one cycle.
module hub75_bcm_driver
  import hub75_pkg::*;
#(
  parameter int unsigned COLS       = 64,
  parameter int unsigned SCAN_ROWS  = 16,
  parameter int unsigned COLOR_BITS = 8,
  parameter int unsigned BASE_TICKS = 16,
  localparam int unsigned ROW_W     = clog2(SCAN_ROWS),
  localparam int unsigned COL_W     = clog2(COLS)
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [1:0]                RED,
  output logic [1:0]                GREEN,
  output logic [1:0]                BLUE,
  output logic [ROW_W-1:0]          A,
  output logic                      LE,
  output logic                      OE_N,
  output logic                      CLK,
  input  logic                      selected_buffer,
  output logic                      actual_buffer,
  output logic [ROW_W+COL_W:0]      rd_addr,
  input  logic [3*COLOR_BITS-1:0]   rd_data_hi,
  input  logic [3*COLOR_BITS-1:0]   rd_data_lo,
  input  logic [7:0]                brightness,
  output logic                      frame_start
);

  localparam int unsigned PLANE_W = (COLOR_BITS > 1) ? clog2(COLOR_BITS) : 1;
  localparam int unsigned TW      = clog2(BASE_TICKS << (COLOR_BITS - 1)) + 1;

  state_t               state, state_next;
  logic [COL_W-1:0]     col;
  logic [ROW_W-1:0]     row;
  logic [PLANE_W-1:0]   plane;
  logic [7:0]           brightness_q;
  logic                 frame_edge;
  logic [7:0]           bright_eff;
  logic [TW-1:0]        load_val;
  logic [TW-1:0]        on_ticks;
  logic [TW+7:0]        product;
  logic                 timer_done;
  logic [COLOR_BITS-1:0] hi_r, hi_g, hi_b, lo_r, lo_g, lo_b;

  assign hi_r = rd_data_hi[RED_FIELD*COLOR_BITS   +: COLOR_BITS];
  assign hi_g = rd_data_hi[GREEN_FIELD*COLOR_BITS +: COLOR_BITS];
  assign hi_b = rd_data_hi[BLUE_FIELD*COLOR_BITS  +: COLOR_BITS];
  assign lo_r = rd_data_lo[RED_FIELD*COLOR_BITS   +: COLOR_BITS];
  assign lo_g = rd_data_lo[GREEN_FIELD*COLOR_BITS +: COLOR_BITS];
  assign lo_b = rd_data_lo[BLUE_FIELD*COLOR_BITS  +: COLOR_BITS];

  assign rd_addr    = {actual_buffer, row, col};
  assign frame_edge = (row == '0) && (plane == '0);
  // The frame-start latch already uses the newly sampled brightness.
  assign bright_eff = frame_edge ? brightness : brightness_q;
  assign load_val   = TW'(BASE_TICKS) << plane;
  assign product    = {8'd0, load_val} * {{TW{1'b0}}, bright_eff};
  assign on_ticks   = product[TW+7:8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SHIFT_ADDR;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SHIFT_ADDR: state_next = SHIFT_LO;
      SHIFT_LO:   state_next = SHIFT_HI;
      // col has already stepped past the last column (wrapped to 0) here.
      SHIFT_HI:   state_next = (col == '0) ? WAIT : SHIFT_LO;
      WAIT:       state_next = timer_done ? BLANK : WAIT;
      BLANK:      state_next = LATCH;
      LATCH:      state_next = UNBLANK;
      UNBLANK:    state_next = SHIFT_ADDR;
      default:    state_next = SHIFT_ADDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RED           <= '0;
      GREEN         <= '0;
      BLUE          <= '0;
      A             <= '0;
      LE            <= 1'b0;
      CLK           <= 1'b0;
      actual_buffer <= 1'b0;
      frame_start   <= 1'b0;
      brightness_q  <= '0;
      col           <= '0;
      row           <= '0;
      plane         <= '0;
    end else begin
      CLK         <= (state == SHIFT_HI);
      LE          <= (state == LATCH);
      frame_start <= (state == LATCH) && frame_edge;
      case (state)
        SHIFT_LO: begin
          RED   <= {lo_r[plane], hi_r[plane]};
          GREEN <= {lo_g[plane], hi_g[plane]};
          BLUE  <= {lo_b[plane], hi_b[plane]};
          col   <= col + 1'b1;
        end
        LATCH: begin
          A <= row;
          if (frame_edge) begin
            actual_buffer <= selected_buffer;
            brightness_q  <= brightness;
          end
        end
        UNBLANK: begin
          if (plane == PLANE_W'(COLOR_BITS - 1)) begin
            plane <= '0;
            row   <= (row == ROW_W'(SCAN_ROWS - 1)) ? '0 : row + 1'b1;
          end else begin
            plane <= plane + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  hub75_plane_timer #(
    .TW (TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst),
    .load     (state == LATCH),
    .blank    ((state == BLANK) || (state == LATCH)),
    .load_val (load_val),
    .on_ticks (on_ticks),
    .oe_n     (OE_N),
    .done     (timer_done)
  );

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Self-checking bench for hub75_bcm_driver: randomized frame RAM contents,
// brightness and buffer requests, checked against a plane/row/frame model.
module tb_hub75_bcm_driver;

  localparam int unsigned COLS  = 4;
  localparam int unsigned SR    = 2;
  localparam int unsigned CB    = 2;
  localparam int unsigned BT    = 4;
  localparam int unsigned ROW_W = 1;
  localparam int unsigned COL_W = 2;
  localparam int unsigned DW    = 3 * CB;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic rst;
  logic [1:0] red, green, blue;
  logic [ROW_W-1:0] a;
  logic le, oe_n, pclk, selected_buffer, actual_buffer, frame_start;
  logic [ROW_W+COL_W:0] rd_addr;
  logic [DW-1:0] rd_hi, rd_lo;
  logic [7:0] brightness;
  logic [DW-1:0] mem_hi [2*SR*COLS];
  logic [DW-1:0] mem_lo [2*SR*COLS];

  always @(posedge clk) begin
    rd_hi <= mem_hi[rd_addr];
    rd_lo <= mem_lo[rd_addr];
  end

  hub75_bcm_driver #(
    .COLS(COLS), .SCAN_ROWS(SR), .COLOR_BITS(CB), .BASE_TICKS(BT)
  ) dut (
    .clk(clk), .rst(rst), .RED(red), .GREEN(green), .BLUE(blue), .A(a),
    .LE(le), .OE_N(oe_n), .CLK(pclk), .selected_buffer(selected_buffer),
    .actual_buffer(actual_buffer), .rd_addr(rd_addr), .rd_data_hi(rd_hi),
    .rd_data_lo(rd_lo), .brightness(brightness), .frame_start(frame_start)
  );

  // short-plane instance: shift outlasts every plane
  logic rst6;
  logic [1:0] red6, green6, blue6;
  logic [ROW_W-1:0] a6;
  logic le6, oe6, pclk6, actual6, fs6;
  logic [ROW_W+COL_W:0] rd_addr6;
  logic [DW-1:0] zero6;
  assign zero6 = '0;

  hub75_bcm_driver #(
    .COLS(COLS), .SCAN_ROWS(SR), .COLOR_BITS(CB), .BASE_TICKS(1)
  ) dut6 (
    .clk(clk), .rst(rst6), .RED(red6), .GREEN(green6), .BLUE(blue6), .A(a6),
    .LE(le6), .OE_N(oe6), .CLK(pclk6), .selected_buffer(1'b0),
    .actual_buffer(actual6), .rd_addr(rd_addr6), .rd_data_hi(zero6),
    .rd_data_lo(zero6), .brightness(8'hFF), .frame_start(fs6)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected {lower,upper} bit of one channel for a given pixel and plane.
  function automatic logic [31:0] exp_color(input int unsigned field, input int unsigned bsel,
                                            input int unsigned row, input int unsigned col,
                                            input int unsigned plane);
    int unsigned idx;
    logic [DW-1:0] hs, ls;
    idx = bsel * SR * COLS + row * COLS + col;
    hs  = mem_hi[idx] >> (field * CB + plane);
    ls  = mem_lo[idx] >> (field * CB + plane);
    return 32'({ls[0], hs[0]});
  endfunction

  // inputs as seen by the DUT at the latest rising edge
  logic sel_edge;
  logic [7:0] bri_edge;
  always @(posedge clk) begin
    sel_edge <= selected_buffer;
    bri_edge <= brightness;
  end

  // model state for the main instance
  int unsigned latches, edge_cnt, lit_cnt, exp_lit, model_buf, model_bri, k_row, k_plane;
  logic have_plane, pclk_prev, le_prev;
  logic [ROW_W-1:0] a_prev;

  always @(negedge clk) begin
    if (!rst) begin
      latches = 0; edge_cnt = 0; lit_cnt = 0; exp_lit = 0;
      model_buf = 0; model_bri = 0; have_plane = 1'b0;
      pclk_prev = 1'b0; le_prev = 1'b0; a_prev = '0;
    end else begin
      k_row   = (latches / CB) % SR;
      k_plane = latches % CB;
      if (a !== a_prev) check("a_change_blanked", 32'(oe_n), 32'd1);
      if (le) begin
        check("le_blanked", 32'(oe_n), 32'd1);
        check("le_width", 32'(le_prev), 32'd0);
      end
      check("frame_start", 32'(frame_start), 32'(le && !le_prev && k_row == 0 && k_plane == 0));
      if (!oe_n) lit_cnt++;
      if (pclk && !pclk_prev) begin
        check("red",   32'(red),   exp_color(0, model_buf, k_row, edge_cnt % COLS, k_plane));
        check("green", 32'(green), exp_color(1, model_buf, k_row, edge_cnt % COLS, k_plane));
        check("blue",  32'(blue),  exp_color(2, model_buf, k_row, edge_cnt % COLS, k_plane));
        edge_cnt++;
      end
      if (le && !le_prev) begin
        check("clk_edges", edge_cnt, COLS);
        check("row_addr", 32'(a), k_row);
        if (have_plane) check("lit_cycles", lit_cnt, exp_lit);
        if (k_row == 0 && k_plane == 0) begin
          model_buf = 32'(sel_edge);
          model_bri = 32'(bri_edge);
        end
        exp_lit    = ((BT << k_plane) * model_bri) >> 8;
        have_plane = 1'b1;
        lit_cnt    = 0;
        edge_cnt   = 0;
        latches++;
      end
      check("actual_buffer", 32'(actual_buffer), model_buf);
      pclk_prev = pclk;
      le_prev   = le;
      a_prev    = a;
    end
  end

  // observation of the short-plane instance
  int unsigned latches6, edges6;
  int unsigned a6_q[$];
  logic le6_prev, pclk6_prev;

  always @(negedge clk) begin
    if (!rst6) begin
      latches6 = 0; edges6 = 0; a6_q.delete();
      le6_prev = 1'b0; pclk6_prev = 1'b0;
    end else begin
      if (pclk6 && !pclk6_prev) begin
        check("d6_rgb", 32'({red6, green6, blue6}), 32'd0);
        edges6++;
      end
      if (le6 && !le6_prev) begin
        check("d6_clk_edges", edges6, COLS);
        check("d6_le_blanked", 32'(oe6), 32'd1);
        check("d6_frame_start", 32'(fs6), 32'(latches6 % (SR * CB) == 0));
        check("d6_rd_addr", 32'({actual6, rd_addr6}), ((latches6 / CB) % SR) * COLS);
        a6_q.push_back(32'(a6));
        latches6++;
        edges6 = 0;
      end
      le6_prev   = le6;
      pclk6_prev = pclk6;
    end
  end

  logic found;

  initial begin
    rst = 1'b0; rst6 = 1'b0;
    selected_buffer = 1'b0;
    brightness = 8'd255;
    for (int i = 0; i < 2 * SR * COLS; i++) begin
      mem_hi[i] = DW'($urandom);
      mem_lo[i] = DW'($urandom);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_oe_n", 32'(oe_n), 32'd1);
    check("rst_le", 32'(le), 32'd0);
    check("rst_clk", 32'(pclk), 32'd0);
    check("rst_a", 32'(a), 32'd0);
    check("rst_rgb", 32'({red, green, blue}), 32'd0);
    check("rst_buffer", 32'(actual_buffer), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    @(posedge clk); #2;
    rst = 1'b1; rst6 = 1'b1;
    @(negedge clk);
    check("first_rd_addr", 32'(rd_addr), 32'd0);

    for (int ph = 0; ph < 12; ph++) begin
      @(posedge clk); #2;
      case (ph % 4)
        0:       brightness = 8'd255;
        1:       brightness = 8'd0;
        2:       brightness = 8'd128;
        default: brightness = 8'($urandom);
      endcase
      if ($urandom_range(0, 1) == 1) selected_buffer = ~selected_buffer;
      repeat ($urandom_range(100, 250)) @(posedge clk);
      if (ph == 5) begin
        // reset while a lit plane is on the panel and a shift is in flight
        brightness = 8'd255;
        repeat (150) @(posedge clk);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
          @(negedge clk);
          if (!oe_n && pclk) found = 1'b1;
        end
        check("rst_window_found", 32'(found), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_oe_n", 32'(oe_n), 32'd1);
        check("midrst_clk", 32'(pclk), 32'd0);
        check("midrst_le", 32'(le), 32'd0);
        check("midrst_a", 32'(a), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_rd_addr", 32'(rd_addr), 32'd0);
      end
    end

    check("progress", 32'(latches > 20), 32'd1);
    check("d6_latch_count", 32'(a6_q.size() >= 8), 32'd1);
    for (int i = 0; i < 8 && i < a6_q.size(); i++)
      check("d6_row_seq", a6_q[i], 32'((i / CB) % SR));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
